// File: rtl/display_scan_controller.sv
// display_scan_controller
// Refresh scheduler for a multiplexed seven-segment display. A programmable
// prescaler produces a one-cycle tick in the clk domain. A small FSM walks the
// digits with an all-anodes-off guard interval between slots. Each slot latches
// its digit's nibble, decimal point and blank bit on entry and drives the
// decoded active-low segment pattern until the slot ends.

module display_scan_controller #(
  parameter int DIV_WIDTH    = 18,
  parameter int NUM_DIGITS   = 8,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          div_load,
  input  logic [DIV_WIDTH-1:0]          div_value,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [6:0]                    seg_n,
  output logic                          dp_n,
  output logic                          tick,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int GW    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Active-low anode pattern with only the selected digit pulled low.
  function automatic logic [NUM_DIGITS-1:0] an_onehot_n(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] one;
    one = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    return ~(one << idx);
  endfunction

  // Prescaler state
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 tick_q, tick_d;

  // Scan FSM state and registered display outputs
  state_t               state_q;
  logic [GW-1:0]        guard_q;
  logic [IDX_W-1:0]     digit_idx_q;
  logic [NUM_DIGITS-1:0] an_n_q;
  logic [6:0]           seg_n_q;
  logic                 dp_n_q;

  logic                 adv_s;
  logic [IDX_W-1:0]     next_idx_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic [3:0]           nibble_s;
  logic [NUM_DIGITS-1:0] show_an_s;
  logic [6:0]           show_seg_s;
  logic                 show_dp_s;

  // Prescaler next state: load clears the count and suppresses the tick; the
  // tick register is set for the cycle in which the count sits at the terminal value.
  always_comb begin
    if (div_load) begin
      div_d = div_value;
      cnt_d = {DIV_WIDTH{1'b0}};
    end else begin
      div_d = div_q;
      if (cnt_q == div_q) begin
        cnt_d = {DIV_WIDTH{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      end
    end
    tick_d = ~div_load & (cnt_d == div_d);
  end

  // Prescaler registers; free-running regardless of enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= {DIV_WIDTH{1'b0}};
      div_q  <= {DIV_WIDTH{1'b1}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  // Slot-entry values: the digit about to be shown is the next one when leaving GUARD.
  always_comb begin
    adv_s = tick_q & ~div_load;
    if (digit_idx_q == IDX_W'(NUM_DIGITS-1)) begin
      next_idx_s = {IDX_W{1'b0}};
    end else begin
      next_idx_s = digit_idx_q + IDX_W'(1);
    end
    if (state_q == S_GUARD) begin
      sel_idx_s = next_idx_s;
    end else begin
      sel_idx_s = digit_idx_q;
    end
    nibble_s = digits_in[{sel_idx_s, 2'b00} +: 4];
    if (blank_mask[sel_idx_s]) begin
      show_an_s = {NUM_DIGITS{1'b1}};
    end else begin
      show_an_s = an_onehot_n(sel_idx_s);
    end
    show_seg_s = seg_decode(nibble_s);
    show_dp_s  = ~dp_in[sel_idx_s];
  end

  // Scan FSM; outputs are loaded on SHOW entry so mid-slot input changes stay hidden.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      guard_q     <= {GW{1'b0}};
      digit_idx_q <= {IDX_W{1'b0}};
      an_n_q      <= {NUM_DIGITS{1'b1}};
      seg_n_q     <= 7'h7F;
      dp_n_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          guard_q     <= {GW{1'b0}};
          digit_idx_q <= {IDX_W{1'b0}};
          if (enable && adv_s) begin
            state_q <= S_SHOW;
            an_n_q  <= show_an_s;
            seg_n_q <= show_seg_s;
            dp_n_q  <= show_dp_s;
          end else begin
            an_n_q  <= {NUM_DIGITS{1'b1}};
            seg_n_q <= 7'h7F;
            dp_n_q  <= 1'b1;
          end
        end
        S_SHOW: begin
          if (!enable) begin
            state_q     <= S_IDLE;
            guard_q     <= {GW{1'b0}};
            digit_idx_q <= {IDX_W{1'b0}};
            an_n_q      <= {NUM_DIGITS{1'b1}};
            seg_n_q     <= 7'h7F;
            dp_n_q      <= 1'b1;
          end else if (adv_s) begin
            state_q <= S_GUARD;
            guard_q <= {GW{1'b0}};
            an_n_q  <= {NUM_DIGITS{1'b1}};
          end
        end
        S_GUARD: begin
          if (!enable) begin
            state_q     <= S_IDLE;
            guard_q     <= {GW{1'b0}};
            digit_idx_q <= {IDX_W{1'b0}};
            an_n_q      <= {NUM_DIGITS{1'b1}};
            seg_n_q     <= 7'h7F;
            dp_n_q      <= 1'b1;
          end else if (guard_q == GW'(GUARD_CYCLES-1)) begin
            state_q     <= S_SHOW;
            guard_q     <= {GW{1'b0}};
            digit_idx_q <= next_idx_s;
            an_n_q      <= show_an_s;
            seg_n_q     <= show_seg_s;
            dp_n_q      <= show_dp_s;
          end else begin
            guard_q <= guard_q + GW'(1);
          end
        end
        default: begin
          state_q     <= S_IDLE;
          guard_q     <= {GW{1'b0}};
          digit_idx_q <= {IDX_W{1'b0}};
          an_n_q      <= {NUM_DIGITS{1'b1}};
          seg_n_q     <= 7'h7F;
          dp_n_q      <= 1'b1;
        end
      endcase
    end
  end

  assign an_n      = an_n_q;
  assign seg_n     = seg_n_q;
  assign dp_n      = dp_n_q;
  assign tick      = tick_q;
  assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller with DIV_WIDTH=8,
// NUM_DIGITS=4, GUARD_CYCLES=2. Expected slots are queued when stimulus is
// applied and popped when the DUT opens a new display slot.

module tb_display_scan_controller;

  localparam int DW = 8;
  localparam int ND = 4;
  localparam int GC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          div_load;
  logic [DW-1:0] div_value;
  logic          enable;
  logic [15:0]   digits_in;
  logic [3:0]    dp_in;
  logic [3:0]    blank_mask;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic          tick;
  logic [1:0]    digit_idx;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  display_scan_controller #(
    .DIV_WIDTH(DW), .NUM_DIGITS(ND), .GUARD_CYCLES(GC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .div_load(div_load), .div_value(div_value),
    .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
    .blank_mask(blank_mask), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n),
    .tick(tick), .digit_idx(digit_idx)
  );

  // Reference segment table, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic exp_t mk_exp(input int k, input logic [15:0] digs,
                                  input logic [3:0] dps, input logic [3:0] blank);
    exp_t e;
    e.an  = blank[k] ? 4'hF : (4'hF & ~(4'h1 << k));
    e.seg = ref_seg(digs[4*k +: 4]);
    e.dp  = ~dps[k];
    e.idx = 2'(k);
    return e;
  endfunction

  // Number of rising edges until tick is seen high (sampled on negedge); -1 on timeout.
  task automatic count_to_tick(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); @(negedge clk);
      if (tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; enable = 1'b0; div_load = 1'b0; div_value = '0;
    digits_in = 16'h0000; dp_in = 4'h0; blank_mask = 4'h0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL reset_an got %h exp %h", an_n, 4'hF); end
    checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp %h", seg_n, 7'h7F); end
    checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp_n); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", digit_idx); end
    // Count 0..255 after release: tick lands 255 edges after the first post-reset cycle.
    count_to_tick(300, n);
    checks++; if (n != 255) begin errors++; $display("FAIL reset_first_tick got %0d exp %0d", n, 255); end
    count_to_tick(300, n);
    checks++; if (n != 256) begin errors++; $display("FAIL reset_tick_period got %0d exp %0d", n, 256); end
  endtask

  task automatic test_load();
    int n;
    div_value = 8'd9;
    div_load  = 1'b1;
    @(posedge clk); @(negedge clk);
    div_load = 1'b0;
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL load_no_tick got %b exp 0", tick); end
    count_to_tick(50, n);
    checks++; if (n != 9) begin errors++; $display("FAIL load_first_tick got %0d exp %0d", n, 9); end
    for (int p = 0; p < 3; p++) begin
      count_to_tick(50, n);
      checks++; if (n != 10) begin errors++; $display("FAIL load_period got %0d exp %0d", n, 10); end
    end
  endtask

  task automatic test_scan();
    exp_t       e;
    logic [3:0] prev_an;
    int         gap;
    bit         seen;
    digits_in  = 16'h3A0F;
    dp_in      = 4'b0100;
    blank_mask = 4'b0000;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < ND; k++)
        sb_q.push_back(mk_exp(k, digits_in, dp_in, blank_mask));
    enable  = 1'b1;
    prev_an = an_n;
    gap     = 0;
    seen    = 1'b0;
    for (int cyc = 0; cyc < 400 && sb_q.size() > 0; cyc++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ($countones(~an_n) > 1) begin errors++; $display("FAIL scan_onehot got %b exp at most one low", an_n); end
      if (an_n !== 4'hF) begin
        if (prev_an === 4'hF) begin
          e = sb_q.pop_front();
          checks++; if (an_n !== e.an) begin errors++; $display("FAIL scan_an got %h exp %h", an_n, e.an); end
          checks++; if (seg_n !== e.seg) begin errors++; $display("FAIL scan_seg got %h exp %h", seg_n, e.seg); end
          checks++; if (dp_n !== e.dp) begin errors++; $display("FAIL scan_dp got %b exp %b", dp_n, e.dp); end
          checks++; if (digit_idx !== e.idx) begin errors++; $display("FAIL scan_idx got %0d exp %0d", digit_idx, e.idx); end
          if (seen) begin
            checks++; if (gap != GC) begin errors++; $display("FAIL scan_guard_gap got %0d exp %0d", gap, GC); end
          end
          seen = 1'b1;
          gap  = 0;
        end
      end else if (seen) begin
        gap++;
      end
      prev_an = an_n;
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL scan_timeout got %0d left exp 0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_blank_snapshot();
    exp_t       e;
    logic [1:0] prev_idx;
    int         in_slot1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL blank_idle_idx got %0d exp 0", digit_idx); end
    blank_mask = 4'b0010;
    digits_in  = 16'h3A0F;
    dp_in      = 4'b0100;
    sb_q.push_back(mk_exp(1, 16'h3A0F, 4'b0100, 4'b0010));
    sb_q.push_back(mk_exp(2, 16'h5B7C, 4'b0100, 4'b0010));
    enable   = 1'b1;
    prev_idx = digit_idx;
    in_slot1 = 0;
    for (int cyc = 0; cyc < 300 && sb_q.size() > 0; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (digit_idx !== prev_idx) begin
        e = sb_q.pop_front();
        checks++; if (an_n !== e.an) begin errors++; $display("FAIL blank_entry_an got %h exp %h", an_n, e.an); end
        checks++; if (seg_n !== e.seg) begin errors++; $display("FAIL blank_entry_seg got %h exp %h", seg_n, e.seg); end
        checks++; if (dp_n !== e.dp) begin errors++; $display("FAIL blank_entry_dp got %b exp %b", dp_n, e.dp); end
      end
      if (digit_idx === 2'd1) begin
        in_slot1++;
        if (in_slot1 == 3) digits_in = 16'h5B7C;
        checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL blank_an_off got %h exp %h", an_n, 4'hF); end
        checks++; if (seg_n !== 7'h40) begin errors++; $display("FAIL snapshot_seg got %h exp %h", seg_n, 7'h40); end
      end
      prev_idx = digit_idx;
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL blank_timeout got %0d left exp 0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_disable();
    bit found;
    blank_mask = 4'b0000;
    found = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (an_n === 4'b1011) begin found = 1'b1; break; end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL disable_wait_digit2 got %h exp %h", an_n, 4'b1011); end
    enable = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL disable_an got %h exp %h", an_n, 4'hF); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL disable_idx got %0d exp 0", digit_idx); end
    checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL disable_seg got %h exp %h", seg_n, 7'h7F); end
    checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL disable_dp got %b exp 1", dp_n); end
  endtask

  task automatic test_back_to_back();
    int n;
    count_to_tick(20, n);
    checks++; if (n < 1) begin errors++; $display("FAIL b2b_sync got %0d exp tick within 20", n); end
    // Load lands in the tick cycle while enable rises: no tick, FSM stays idle.
    enable    = 1'b1;
    div_value = 8'd9;
    div_load  = 1'b1;
    @(posedge clk); @(negedge clk);
    div_load = 1'b0;
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL b2b_tick got %b exp 0", tick); end
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL b2b_no_advance got %h exp %h", an_n, 4'hF); end
    count_to_tick(20, n);
    checks++; if (n != 9) begin errors++; $display("FAIL b2b_next_tick got %0d exp %0d", n, 9); end
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL b2b_idle_at_tick got %h exp %h", an_n, 4'hF); end
    @(posedge clk); @(negedge clk);
    checks++; if (an_n !== 4'hE) begin errors++; $display("FAIL b2b_show_an got %h exp %h", an_n, 4'hE); end
    checks++; if (seg_n !== ref_seg(digits_in[3:0])) begin errors++; $display("FAIL b2b_show_seg got %h exp %h", seg_n, ref_seg(digits_in[3:0])); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit found;
    found = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (an_n === 4'hF) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_wait_guard got %h exp %h", an_n, 4'hF); end
    rst_n  = 1'b0;
    enable = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL midrst_an got %h exp %h", an_n, 4'hF); end
    checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL midrst_seg got %h exp %h", seg_n, 7'h7F); end
    checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL midrst_dp got %b exp 1", dp_n); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL midrst_tick got %b exp 0", tick); end
    checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL midrst_idx got %0d exp 0", digit_idx); end
    count_to_tick(300, n);
    checks++; if (n != 255) begin errors++; $display("FAIL midrst_div_reset got %0d exp %0d", n, 255); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_scan();
    test_blank_snapshot();
    test_disable();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
